// File: rtl/hsv_pkg.sv
// Shared constants for the HSV adjust controller: register map,
// control-word bit positions, sideband layout and controller states.
package hsv_pkg;

  localparam logic [1:0] ADDR_HUE  = 2'd0;
  localparam logic [1:0] ADDR_SAT  = 2'd1;
  localparam logic [1:0] ADDR_VAL  = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_COMMIT = 1;

  localparam int USER_SOF = 0;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/hsv_gain_sat.sv
// One gain lane: stage 0 registers the full-width product, stage 1
// registers the fixed-point shift and clamp to the component range.
module hsv_gain_sat #(
  parameter int HSV_DEPTH  = 8,
  parameter int GAIN_WIDTH = 8,
  parameter int GAIN_FRAC  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_p0_i,
  input  logic                  ld_p1_i,
  input  logic [HSV_DEPTH-1:0]  comp_i,
  input  logic [GAIN_WIDTH-1:0] gain_i,
  output logic [HSV_DEPTH-1:0]  comp_o
);

  localparam int PROD_W = HSV_DEPTH + GAIN_WIDTH;

  logic [PROD_W-1:0]    prod_p0;
  logic [HSV_DEPTH-1:0] res_p1;

  // Drop the fractional bits, then clamp anything above full scale.
  function automatic logic [HSV_DEPTH-1:0] shift_sat(input logic [PROD_W-1:0] prod);
    logic [PROD_W-1:0] shifted;
    shifted = prod >> GAIN_FRAC;
    if (|shifted[PROD_W-1:HSV_DEPTH])
      return '1;
    else
      return shifted[HSV_DEPTH-1:0];
  endfunction

  // Stage 0: full-precision product, captured only for accepted beats.
  always_ff @(posedge clk) begin
    if (ld_p0_i)
      prod_p0 <= PROD_W'(comp_i) * PROD_W'(gain_i);
  end

  // Stage 1: shift and saturate; this register drives the block output.
  always_ff @(posedge clk) begin
    if (reset)
      res_p1 <= '0;
    else if (ld_p1_i)
      res_p1 <= shift_sat(prod_p0);
  end

  assign comp_o = res_p1;

endmodule

// File: rtl/hsv_adjust_ctrl.sv
// Frame-synchronous HSV adjust: shadow/active settings committed on SOF,
// applied to the pixel stream through a 2-stage valid/ready pipeline.
module hsv_adjust_ctrl
  import hsv_pkg::*;
#(
  parameter int HSV_DEPTH  = 8,
  parameter int GAIN_WIDTH = 8,
  parameter int GAIN_FRAC  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [3*HSV_DEPTH-1:0] in_data,
  input  logic [7:0]             in_user,
  output logic                   out_valid,
  output logic [3*HSV_DEPTH-1:0] out_data,
  output logic [7:0]             out_user,
  input  logic                   in_ready,
  output logic                   out_ready,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_addr,
  input  logic [7:0]             cfg_wdata,
  output logic                   cfg_pending,
  output logic [15:0]            frame_cnt
);

  localparam logic [GAIN_WIDTH-1:0] GAIN_ONE = GAIN_WIDTH'(1 << GAIN_FRAC);

  // Settings: shadow (software view) and active (datapath view).
  logic [HSV_DEPTH-1:0]  hue_sh_q, hue_act_q;
  logic [GAIN_WIDTH-1:0] sat_sh_q, sat_act_q;
  logic [GAIN_WIDTH-1:0] val_sh_q, val_act_q;
  logic                  en_sh_q, en_act_q;

  ctrl_state_e state_q, state_d;
  logic [15:0] frame_cnt_q;

  // Pipeline control and data.
  logic                 vld_p0, vld_p1;
  logic [HSV_DEPTH-1:0] h_p0, h_p1;
  logic [7:0]           user_p0, user_p1;
  logic [HSV_DEPTH-1:0] s_p1, v_p1;

  logic running, accept, sof_acc, commit_now, commit_req, ld_p1;
  logic                  eff_en;
  logic [HSV_DEPTH-1:0]  eff_hue, hue_use, h_in;
  logic [GAIN_WIDTH-1:0] eff_sat, eff_val, sat_use, val_use;

  assign running    = in_ready | ~vld_p1;
  assign out_ready  = running;
  assign accept     = in_valid & running;
  assign sof_acc    = accept & in_user[USER_SOF];
  assign commit_now = (state_q == PEND) & sof_acc;
  assign commit_req = cfg_we & (cfg_addr == ADDR_CTRL) & cfg_wdata[CTRL_COMMIT];
  assign ld_p1      = running & vld_p0;

  // The committing SOF beat must already see the new settings, so it
  // bypasses the active registers that only update at this same edge.
  assign eff_en  = commit_now ? en_sh_q  : en_act_q;
  assign eff_hue = commit_now ? hue_sh_q : hue_act_q;
  assign eff_sat = commit_now ? sat_sh_q : sat_act_q;
  assign eff_val = commit_now ? val_sh_q : val_act_q;

  // Disabled means zero offset and unity gain: identical latency, and
  // (x * 1.0) >> GAIN_FRAC is exact, so data passes through unchanged.
  assign hue_use = eff_en ? eff_hue : '0;
  assign sat_use = eff_en ? eff_sat : GAIN_ONE;
  assign val_use = eff_en ? eff_val : GAIN_ONE;

  assign h_in = in_data[3*HSV_DEPTH-1 -: HSV_DEPTH];

  // Shadow registers: written directly by the config port.
  always_ff @(posedge clk) begin
    if (reset) begin
      hue_sh_q <= '0;
      sat_sh_q <= GAIN_ONE;
      val_sh_q <= GAIN_ONE;
      en_sh_q  <= 1'b0;
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_HUE:  hue_sh_q <= HSV_DEPTH'(cfg_wdata);
        ADDR_SAT:  sat_sh_q <= GAIN_WIDTH'(cfg_wdata);
        ADDR_VAL:  val_sh_q <= GAIN_WIDTH'(cfg_wdata);
        default:   en_sh_q  <= cfg_wdata[CTRL_EN];
      endcase
    end
  end

  // Active registers: copied from pre-write shadow values on a committing SOF.
  always_ff @(posedge clk) begin
    if (reset) begin
      hue_act_q <= '0;
      sat_act_q <= GAIN_ONE;
      val_act_q <= GAIN_ONE;
      en_act_q  <= 1'b0;
    end else if (commit_now) begin
      hue_act_q <= hue_sh_q;
      sat_act_q <= sat_sh_q;
      val_act_q <= val_sh_q;
      en_act_q  <= en_sh_q;
    end
  end

  // Controller next state: a fresh request always wins over a same-cycle SOF.
  always_comb begin
    state_d = state_q;
    if (commit_req)
      state_d = PEND;
    else if (commit_now)
      state_d = RUN;
  end

  // Controller state and SOF counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (sof_acc)
        frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // ---- stage 0: hue add (multiply lives in the gain lanes) ----
  // Stage 0 valid advances whenever the pipe runs.
  always_ff @(posedge clk) begin
    if (reset)
      vld_p0 <= 1'b0;
    else if (running)
      vld_p0 <= in_valid;
  end

  // Stage 0 data loads only for accepted beats; bubbles keep old contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      h_p0    <= h_in + hue_use;
      user_p0 <= in_user;
    end
  end

  // ---- stage 1: shift/saturate, output registers ----
  // Stage 1 valid advances whenever the pipe runs.
  always_ff @(posedge clk) begin
    if (reset)
      vld_p1 <= 1'b0;
    else if (running)
      vld_p1 <= vld_p0;
  end

  // Stage 1 hue and sideband, cleared on reset since they face the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_p1    <= '0;
      user_p1 <= '0;
    end else if (ld_p1) begin
      h_p1    <= h_p0;
      user_p1 <= user_p0;
    end
  end

  hsv_gain_sat #(
    .HSV_DEPTH (HSV_DEPTH),
    .GAIN_WIDTH(GAIN_WIDTH),
    .GAIN_FRAC (GAIN_FRAC)
  ) u_sat (
    .clk    (clk),
    .reset  (reset),
    .ld_p0_i(accept),
    .ld_p1_i(ld_p1),
    .comp_i (in_data[2*HSV_DEPTH-1 -: HSV_DEPTH]),
    .gain_i (sat_use),
    .comp_o (s_p1)
  );

  hsv_gain_sat #(
    .HSV_DEPTH (HSV_DEPTH),
    .GAIN_WIDTH(GAIN_WIDTH),
    .GAIN_FRAC (GAIN_FRAC)
  ) u_val (
    .clk    (clk),
    .reset  (reset),
    .ld_p0_i(accept),
    .ld_p1_i(ld_p1),
    .comp_i (in_data[HSV_DEPTH-1:0]),
    .gain_i (val_use),
    .comp_o (v_p1)
  );

  assign out_valid   = vld_p1;
  assign out_data    = {h_p1, s_p1, v_p1};
  assign out_user    = user_p1;
  assign cfg_pending = (state_q == PEND);
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_hsv_adjust_ctrl.sv
// Directed bench for hsv_adjust_ctrl: vector table plus hand sequences
// for commit timing, backpressure and mid-frame reset.
module tb_hsv_adjust_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [23:0] in_data;
  logic [7:0]  in_user;
  logic        out_valid;
  logic [23:0] out_data;
  logic [7:0]  out_user;
  logic        in_ready;
  logic        out_ready;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        cfg_pending;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] h, s, v, user;
    logic [7:0] eh, es, ev;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  hsv_adjust_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_user    (in_user),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_user   (out_user),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_pending(cfg_pending),
    .frame_cnt  (frame_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v,
                      input logic [7:0] user, input logic we, input logic [1:0] addr,
                      input logic [7:0] wd);
    in_valid  = 1'b1;
    in_data   = {h, s, v};
    in_user   = user;
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_wdata = wd;
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [7:0] wd);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = wd;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [7:0] eh, input logic [7:0] es,
                            input logic [7:0] ev, input logic [7:0] eu);
    tick();
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_h"}, out_data[23:16], eh);
    chk({name, "_s"}, out_data[15:8], es);
    chk({name, "_v"}, out_data[7:0], ev);
    chk({name, "_user"}, out_user, eu);
  endtask

  task automatic hue_wrap_seq();
    cfg_write(2'd0, 8'd100);
    cfg_write(2'd3, 8'h03);
    chk("hue_pend_set", cfg_pending, 1);
    chk("hue_fcnt_before", frame_cnt, 0);
    beat(8'd200, 8'd10, 8'd20, 8'h01, 1'b0, 2'd0, 8'd0);
    chk("hue_pend_clr", cfg_pending, 0);
    chk("hue_fcnt_after", frame_cnt, 1);
    expect_out("hue_wrap", 8'd44, 8'd10, 8'd20, 8'h01);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Identity before any commit; the rest run with hue 100, sat 32, val 128.
    vecs[0] = '{8'd200, 8'd100, 8'd50,  8'h5A, 8'd200, 8'd100, 8'd50};
    vecs[1] = '{8'd0,   8'd100, 8'd200, 8'h01, 8'd100, 8'd50,  8'd255};
    vecs[2] = '{8'd10,  8'd0,   8'd100, 8'h80, 8'd110, 8'd0,   8'd200};
    vecs[3] = '{8'd200, 8'd255, 8'd127, 8'h00, 8'd44,  8'd127, 8'd254};
    vecs[4] = '{8'd156, 8'd128, 8'd128, 8'h00, 8'd0,   8'd64,  8'd255};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_user = '0;
    in_ready = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_user", out_user, 0);
    chk("rst_pending", cfg_pending, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_out_ready", out_ready, 1);

    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        hue_wrap_seq();
        cfg_write(2'd1, 8'd32);
        cfg_write(2'd2, 8'd128);
        cfg_write(2'd3, 8'h03);
      end
      beat(vecs[i].h, vecs[i].s, vecs[i].v, vecs[i].user, 1'b0, 2'd0, 8'd0);
      expect_out($sformatf("vec%0d", i), vecs[i].eh, vecs[i].es, vecs[i].ev, vecs[i].user);
    end
    chk("tbl_frame_cnt", frame_cnt, 2);

    // Deferred commit: non-SOF beats keep the old offset.
    cfg_write(2'd0, 8'd10);
    cfg_write(2'd3, 8'h03);
    chk("defer_pend", cfg_pending, 1);
    beat(8'd5, 8'd0, 8'd0, 8'h00, 1'b0, 2'd0, 8'd0);
    expect_out("defer_old", 8'd105, 8'd0, 8'd0, 8'h00);
    chk("defer_still_pend", cfg_pending, 1);
    beat(8'd5, 8'd64, 8'd64, 8'h01, 1'b0, 2'd0, 8'd0);
    chk("defer_pend_clr", cfg_pending, 0);
    expect_out("defer_new", 8'd15, 8'd32, 8'd128, 8'h01);

    // Commit write coincident with an SOF waits for the following SOF.
    cfg_write(2'd0, 8'd50);
    beat(8'd5, 8'd0, 8'd0, 8'h01, 1'b1, 2'd3, 8'h03);
    chk("coinc_pend", cfg_pending, 1);
    expect_out("coinc_sof", 8'd15, 8'd0, 8'd0, 8'h01);
    beat(8'd5, 8'd0, 8'd0, 8'h00, 1'b0, 2'd0, 8'd0);
    expect_out("coinc_next", 8'd15, 8'd0, 8'd0, 8'h00);
    beat(8'd5, 8'd0, 8'd0, 8'h01, 1'b0, 2'd0, 8'd0);
    chk("coinc_pend_clr", cfg_pending, 0);
    expect_out("coinc_commit", 8'd55, 8'd0, 8'd0, 8'h01);

    // Shadow write in the commit cycle: the copy sees the old shadow value.
    cfg_write(2'd0, 8'd20);
    cfg_write(2'd3, 8'h03);
    beat(8'd0, 8'd0, 8'd0, 8'h01, 1'b1, 2'd0, 8'd77);
    chk("prewrite_pend_clr", cfg_pending, 0);
    expect_out("prewrite", 8'd20, 8'd0, 8'd0, 8'h01);
    chk("mid_frame_cnt", frame_cnt, 6);

    // Backpressure: active hue 20, sat 32, val 128.
    in_valid = 1'b1; in_data = {8'd1, 8'd2, 8'd3}; in_user = 8'h10;
    tick();
    in_data = {8'd4, 8'd8, 8'd10}; in_user = 8'h20;
    tick();
    in_data = {8'd30, 8'd40, 8'd50}; in_user = 8'h40;
    in_ready = 1'b0;
    #1;
    chk("bp_ready_low", out_ready, 0);
    chk("bp_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_hold_ready%0d", k), out_ready, 0);
      chk($sformatf("bp_hold_data%0d", k), out_data, {8'd21, 8'd1, 8'd6});
      chk($sformatf("bp_hold_user%0d", k), out_user, 8'h10);
    end
    in_ready = 1'b1;
    #1;
    chk("bp_ready_high", out_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_b_valid", out_valid, 1);
    chk("bp_b_data", out_data, {8'd24, 8'd4, 8'd20});
    chk("bp_b_user", out_user, 8'h20);
    tick();
    chk("bp_c_valid", out_valid, 1);
    chk("bp_c_data", out_data, {8'd50, 8'd20, 8'd100});
    chk("bp_c_user", out_user, 8'h40);
    tick();
    chk("bp_drained", out_valid, 0);

    // Reset with a pending commit and two beats in flight.
    cfg_write(2'd3, 8'h03);
    chk("rstmid_pend", cfg_pending, 1);
    in_valid = 1'b1; in_data = {8'd1, 8'd1, 8'd1}; in_user = 8'h00;
    tick();
    in_data = {8'd2, 8'd2, 8'd2};
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_data", out_data, 0);
    chk("rstmid_pend_clr", cfg_pending, 0);
    chk("rstmid_fcnt", frame_cnt, 0);
    tick();
    chk("rstmid_no_leak", out_valid, 0);
    beat(8'd200, 8'd100, 8'd50, 8'h5A, 1'b0, 2'd0, 8'd0);
    expect_out("rstmid_ident", 8'd200, 8'd100, 8'd50, 8'h5A);
    cfg_write(2'd3, 8'h03);
    beat(8'd9, 8'd9, 8'd9, 8'h01, 1'b0, 2'd0, 8'd0);
    expect_out("rstmid_shadow", 8'd9, 8'd9, 8'd9, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
